// File: rtl/tinker_mem_responder.sv
// Memory-side responder for the Tinker fetch and data ports: a byte-addressed little-endian
// store that serves one request at a time and answers after a fixed latency.
module tinker_mem_responder #(
    parameter int unsigned MEM_BYTES = 524288,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_req_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_write,
    input  logic [63:0] d_req_addr,
    input  logic [63:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [63:0] d_rsp_rdata,
    output logic        d_rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W      = $clog2(MEM_BYTES);
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned WORD_BYTES = 8;
    localparam logic [CNT_W-1:0] WAIT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
    localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic             lastGrantData;

    logic             grantData;
    logic             grantFetch;
    logic             contested;
    logic             accept;
    logic             fetchErr;
    logic             dataErr;

    logic             reqIsData;
    logic             reqWrite;
    logic [IDX_W-1:0] reqIdx;
    logic [63:0]      reqWdata;
    logic             reqErr;

    logic [7:0]       mem [MEM_BYTES];
    logic [63:0]      rdWord;
    logic             commit;
    logic             rspActive;

    // Round-robin: on a tie the port not granted at the last tie wins; lone requests always win.
    always_comb begin
        grantData  = d_req_valid && (!if_req_valid || !lastGrantData);
        grantFetch = if_req_valid && !grantData;
    end

    assign contested = if_req_valid && d_req_valid;
    assign accept    = (state == S_IDLE) && (grantData || grantFetch);

    // 65-bit sums so addresses near 2^64 flag as errors instead of wrapping.
    assign fetchErr = ({1'b0, if_req_addr} + 65'd3) >= MEM_LIMIT;
    assign dataErr  = ({1'b0, d_req_addr} + 65'd7) >= MEM_LIMIT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            count         <= '0;
            lastGrantData <= 1'b0;
        end else begin
            state <= stateNext;
            count <= countNext;
            if (accept && contested) begin
                lastGrantData <= grantData;
            end
        end
    end

    always_comb begin
        stateNext = state;
        countNext = count;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    stateNext = (LATENCY <= 1) ? S_RESP : S_WAIT;
                    countNext = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (count == '0) begin
                    stateNext = S_RESP;
                end else begin
                    countNext = count - CNT_W'(1);
                end
            end
            S_RESP: stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Request is frozen at accept so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            reqIsData <= grantData;
            reqWrite  <= grantData && d_req_write;
            reqIdx    <= grantData ? d_req_addr[IDX_W-1:0] : if_req_addr[IDX_W-1:0];
            reqWdata  <= d_req_wdata;
            reqErr    <= grantData ? dataErr : fetchErr;
        end
    end

    // Stores commit on the RESP->IDLE edge unless reset lands on that same edge.
    assign commit = (state == S_RESP) && reqWrite && !reqErr;

    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                mem[IDX_W'(reqIdx + IDX_W'(i))] <= reqWdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdWord = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rdWord[8*i +: 8] = mem[IDX_W'(reqIdx + IDX_W'(i))];
        end
    end

    assign rspActive    = (state == S_RESP) && !reset;
    assign if_rsp_valid = rspActive && !reqIsData;
    assign if_rsp_err   = if_rsp_valid && reqErr;
    assign if_rsp_data  = (if_rsp_valid && !reqErr) ? rdWord[31:0] : '0;
    assign d_rsp_valid  = rspActive && reqIsData;
    assign d_rsp_err    = d_rsp_valid && reqErr;
    assign d_rsp_rdata  = (d_rsp_valid && !reqWrite && !reqErr) ? rdWord : '0;

    assign if_req_ready = (state == S_IDLE);
    assign d_req_ready  = (state == S_IDLE);
    assign busy         = (state != S_IDLE);

endmodule
